// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the byte-serial shared adder controller.
// Saturation limits are used only when ADDER_SHARE_CTRL_SAT_EN is defined.
package adder_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTE_W = 8;
  localparam int MAX_W  = 256;

  // Signed limit of a width-bit value: 100..0 when neg, 011..1 otherwise.
  function automatic logic [MAX_W-1:0] sat_limit(input int width, input logic neg);
    logic [MAX_W-1:0] lim;
    lim = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1) begin
        lim[i] = ~neg;
      end else if (i == width - 1) begin
        lim[i] = neg;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_slice.sv
// 8-bit combinational add slice; exposes the carry into bit 7 so the
// controller can derive signed overflow on the top byte.
module add8_slice
  import adder_share_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              msb_cin
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    msb_cin     = a[BYTE_W-1] ^ b[BYTE_W-1] ^ sum[BYTE_W-1];
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one 8-bit add slice across NREQ requesters.
// Define ADDER_SHARE_CTRL_SAT_EN to clamp overflowing results to the signed limit.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_n,
  output logic                     rsp_z,
  output logic                     rsp_c,
  output logic                     rsp_v
);

  localparam int NB  = WIDTH / BYTE_W;
  localparam int KW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic              found;
  logic [IDW-1:0]    gnt;
  int                idx;

  logic [BYTE_W-1:0] slice_sum;
  logic              slice_cout;
  logic              slice_msb_cin;
  logic              v_flag;
  logic [WIDTH-1:0]  full_res;
  logic [WIDTH-1:0]  fin_res;

  add8_slice u_slice (
    .a       (a_q[k_q*BYTE_W +: BYTE_W]),
    .b       (b_q[k_q*BYTE_W +: BYTE_W]),
    .cin     (carry_q),
    .sum     (slice_sum),
    .cout    (slice_cout),
    .msb_cin (slice_msb_cin)
  );

  // Scan from the farthest slot back to ptr so the nearest valid requester wins.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = (int'(ptr_q) + j) % NREQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  always_comb begin
    full_res                        = res_q;
    full_res[k_q*BYTE_W +: BYTE_W]  = slice_sum;
    v_flag                          = slice_msb_cin ^ slice_cout;
`ifdef ADDER_SHARE_CTRL_SAT_EN
    fin_res = v_flag ? WIDTH'(sat_limit(WIDTH, a_q[WIDTH-1])) : full_res;
`else
    fin_res = full_res;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = EXEC;
          id_d    = gnt;
          a_d     = req_a[gnt*WIDTH +: WIDTH];
          // Subtract as A + ~B + 1: invert B here, seed the carry with sub.
          b_d     = req_b[gnt*WIDTH +: WIDTH] ^ {WIDTH{req_sub[gnt]}};
          carry_d = req_sub[gnt];
          k_d     = '0;
        end
      end
      EXEC: begin
        res_d   = full_res;
        carry_d = slice_cout;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NB - 1)) begin
          state_d = DONE;
          res_d   = fin_res;
          n_d     = fin_res[WIDTH-1];
          z_d     = (fin_res == '0);
          c_d     = slice_cout;
          v_d     = v_flag;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rstn && state_q == IDLE && found) begin
      req_ready[gnt] = 1'b1;
    end
    rsp_valid  = (state_q == DONE);
    rsp_id     = id_q;
    rsp_result = res_q;
    rsp_n      = n_q;
    rsp_z      = z_q;
    rsp_c      = c_q;
    rsp_v      = v_q;
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl (WIDTH=32, NREQ=2); expectations follow
// ADDER_SHARE_CTRL_SAT_EN when it is defined.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, req_sub;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_n, rsp_z, rsp_c, rsp_v;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  adder_share_ctrl #(.WIDTH(32), .NREQ(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v)
  );

  // Present one request at a negedge, wait for the accept edge, then count
  // posedges until rsp_valid; returns at a negedge with lat (99 = never accepted).
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, output int lat);
    int w;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_sub[id]        = sub;
    req_valid[id]      = 1'b1;
    w = 0;
    #1;
    while (!req_ready[id] && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      lat = 99;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d res=%h nzcv=%b%b%b%b, need all zero",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v);
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle after reset release");
  endtask

  task automatic test_add();
    int lat;
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    checks++;
    if (lat != 4) begin fails++; $display("FAIL add_latency: got %0d, need 4", lat); end
    checks++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_id} !== {32'h0000_0100, 4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL add_result: got %h nzcv=%b%b%b%b id=%0d, need 00000100 nzcv=0000 id=0",
               rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_id);
    end
    $display("add: 000000ff+00000001 -> %h lat=%0d", rsp_result, lat);
    finish_rsp();
  endtask

  task automatic test_sub();
    int lat;
    issue(1, 32'h0000_0001, 32'h0000_0010, 1'b1, lat);
    checks++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_id} !== {32'hFFFF_FFF1, 4'b1000, 1'b1}) begin
      fails++;
      $display("FAIL sub_borrow: got %h nzcv=%b%b%b%b id=%0d, need fffffff1 nzcv=1000 id=1",
               rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_id);
    end
    $display("sub: 00000001-00000010 -> %h", rsp_result);
    finish_rsp();
    issue(1, 32'h1234_5678, 32'h1234_5678, 1'b1, lat);
    checks++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== {32'h0, 4'b0110}) begin
      fails++;
      $display("FAIL sub_zero: got %h nzcv=%b%b%b%b, need 00000000 nzcv=0110",
               rsp_result, rsp_n, rsp_z, rsp_c, rsp_v);
    end
    $display("sub: 12345678-12345678 -> %h", rsp_result);
    finish_rsp();
  endtask

  task automatic test_overflow();
    int lat;
    logic [35:0] exp;
`ifdef ADDER_SHARE_CTRL_SAT_EN
    exp = {32'h7FFF_FFFF, 4'b0001};
`else
    exp = {32'h8000_0000, 4'b1001};
`endif
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    checks++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== exp) begin
      fails++;
      $display("FAIL overflow_pos: got %h nzcv=%b%b%b%b, need %h nzcv=%b",
               rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, exp[35:4], exp[3:0]);
    end
    $display("overflow: 7fffffff+00000001 -> %h", rsp_result);
    finish_rsp();
  endtask

  task automatic test_round_robin();
    int gr[4];
    int ng = 0;
    int nr = 0;
    logic [31:0] exp_res;
    rstn = 1'b0;
    req_a = {32'd10, 32'd5};
    req_b = {32'd4, 32'd3};
    req_sub = 2'b10;
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      fails++; $display("FAIL rr_ready_in_reset: got %b, need 00", req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 100 && nr < 4; cyc++) begin
      if (req_ready == 2'b11) begin
        checks++; fails++; $display("FAIL rr_onehot: got 11, need one-hot or zero");
      end
      if (req_ready != 2'b00 && ng < 4) begin
        gr[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      if (rsp_valid) begin
        exp_res = (nr % 2 == 0) ? 32'd8 : 32'd6;
        checks++;
        if (rsp_id !== 1'((nr % 2)) || rsp_result !== exp_res) begin
          fails++;
          $display("FAIL rr_rsp%0d: got id=%0d res=%h, need id=%0d res=%h",
                   nr, rsp_id, rsp_result, nr % 2, exp_res);
        end
        $display("round_robin: response %0d id=%0d res=%h", nr, rsp_id, rsp_result);
        nr++;
        if (nr == 4) req_valid = 2'b00;
      end
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (ng != 4 || nr != 4) begin
      fails++; $display("FAIL rr_count: got grants=%0d rsps=%0d, need 4 and 4", ng, nr);
    end else begin
      checks++;
      if (gr[0] != 0 || gr[1] != 1 || gr[2] != 0 || gr[3] != 1) begin
        fails++;
        $display("FAIL rr_order: got %0d%0d%0d%0d, need 0101", gr[0], gr[1], gr[2], gr[3]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [35:0] exp;
    logic [36:0] snap;
`ifdef ADDER_SHARE_CTRL_SAT_EN
    exp = {32'h8000_0000, 4'b1011};
`else
    exp = {32'h0000_0000, 4'b0111};
`endif
    issue(1, 32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    checks++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== exp) begin
      fails++;
      $display("FAIL overflow_neg: got %h nzcv=%b%b%b%b, need %h nzcv=%b",
               rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, exp[35:4], exp[3:0]);
    end
    snap = {rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v};
    req_a[31:0] = 32'd1; req_b[31:0] = 32'd1; req_sub[0] = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (!rsp_valid || req_ready !== 2'b00 ||
          {rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== snap) begin
        fails++;
        $display("FAIL hold_cycle%0d: got valid=%b ready=%b res=%h, need valid=1 ready=00 res=%h",
                 i, rsp_valid, req_ready, rsp_result, snap[35:4]);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    $display("backpressure: held response %h for 3 cycles", rsp_result);
    finish_rsp();
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL release_idle: got rsp_valid=%b, need 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    int seen = 0;
    issue(0, 32'd1, 32'd1, 1'b0, lat);
    finish_rsp();
    req_a[63:32] = 32'hAAAA_5555; req_b[63:32] = 32'h1111_2222; req_sub[1] = 1'b0;
    req_valid[1] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      fails++; $display("FAIL mid_grant: got %b, need 10", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got valid=%b id=%0d res=%h nzcv=%b%b%b%b, need all zero",
               rsp_valid, rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v);
    end
    @(negedge clk);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      fails++; $display("FAIL mid_no_rsp: got %0d valid cycles, need 0", seen);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      fails++; $display("FAIL mid_next_grant: got %b, need 01", req_ready);
    end
    req_valid = 2'b00;
    $display("reset_mid_exec: dropped op, next grant ready=%b", req_ready);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
